// File: rtl/muldiv_pkg.sv
// muldiv_pkg: RV32M funct3 codes, FSM states and op-decoding helpers.
// Shared by muldiv_unit, div_core and the muldiv_if users.
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    // Div ops: signed division. Mul ops: rs1 treated as signed.
    function automatic logic is_signed(input logic [2:0] op);
        return op[2] ? ~op[0] : (op != OP_MULHU);
    endfunction

    function automatic logic mul_b_signed(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/response handshake bundle of the mul/div unit.
// master = issuing EX stage, slave = muldiv_unit.
interface muldiv_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             valid_i;
    logic             ready_o;
    logic [2:0]       op_i;
    logic [XLEN-1:0]  a_i;
    logic [XLEN-1:0]  b_i;
    logic [TAG_W-1:0] tag_i;
    logic             valid_o;
    logic             ready_i;
    logic [XLEN-1:0]  result_o;
    logic [TAG_W-1:0] tag_o;

    modport master (
        output valid_i, op_i, a_i, b_i, tag_i, ready_i,
        input  ready_o, valid_o, result_o, tag_o
    );

    modport slave (
        input  valid_i, op_i, a_i, b_i, tag_i, ready_i,
        output ready_o, valid_o, result_o, tag_o
    );
endinterface

// File: rtl/div_core.sv
// div_core: iterative radix-2 restoring divider on unsigned magnitudes.
// One quotient bit per cycle, XLEN cycles; done_o flags the last iteration.
module div_core #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            done_o,
    output logic [XLEN-1:0] q_o,
    output logic [XLEN-1:0] r_o
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    logic            busy;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] q;
    logic [XLEN-1:0] r;
    logic [XLEN-1:0] d;
    logic [XLEN:0]   r_sh;
    logic [XLEN:0]   diff;

    always_comb begin
        r_sh = {r, q[XLEN-1]};
        diff = r_sh - {1'b0, d};
    end

    assign done_o = busy && (cnt == LAST);
    assign q_o    = q;
    assign r_o    = r;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy <= 1'b0;
            cnt  <= '0;
            q    <= '0;
            r    <= '0;
            d    <= '0;
        end else if (abort_i) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start_i) begin
            busy <= 1'b1;
            cnt  <= '0;
            q    <= dividend_i;
            r    <= '0;
            d    <= divisor_i;
        end else if (busy) begin
            // Dividend shifts out of q while quotient bits shift in.
            if (!diff[XLEN]) begin
                r <= diff[XLEN-1:0];
                q <= {q[XLEN-2:0], 1'b1};
            end else begin
                r <= r_sh[XLEN-1:0];
                q <= {q[XLEN-2:0], 1'b0};
            end
            if (cnt == LAST) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M execute unit (pipelined mul, iterative div).
// Define MULDIV_FAST_SPECIAL_EN to finish div-by-zero/overflow in one cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2,
    parameter int TAG_W      = 5
) (
    input logic      clk_i,
    input logic      rst_i,
    input logic      flush_i,
    muldiv_if.slave  bus
);
    localparam int MCW = (MUL_STAGES > 2) ? $clog2(MUL_STAGES) : 1;
    localparam logic [MCW-1:0] MUL_LAST =
        MCW'((MUL_STAGES > 1) ? MUL_STAGES - 2 : 0);
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t           state;
    state_t           state_nx;
    logic             accept;
    logic             fast;
    logic [2:0]       op_q;
    logic [XLEN-1:0]  a_q;
    logic [XLEN-1:0]  b_q;
    logic [TAG_W-1:0] tag_q;
    logic             dz_q;
    logic             ovf_q;
    logic             dz_in;
    logic             ovf_in;
    logic [MCW-1:0]   mcnt;
    logic [XLEN-1:0]  a_abs;
    logic [XLEN-1:0]  b_abs;
    logic [2*XLEN-1:0] a_ext;
    logic [2*XLEN-1:0] b_ext;
    logic [2*XLEN-1:0] prod_in;
    logic [2*XLEN-1:0] prod_q [MUL_STAGES];
    logic [2*XLEN-1:0] prod_last;
    logic             div_done;
    logic [XLEN-1:0]  q_mag;
    logic [XLEN-1:0]  r_mag;
    logic [XLEN-1:0]  q_fix;
    logic [XLEN-1:0]  r_fix;
    logic [XLEN-1:0]  mul_res;
    logic [XLEN-1:0]  div_res;

    assign accept = (state == S_IDLE) && bus.valid_i && !flush_i;
    assign dz_in  = (bus.b_i == '0);
    assign ovf_in = is_signed(bus.op_i) && (bus.a_i == XMIN) && (bus.b_i == '1);

`ifdef MULDIV_FAST_SPECIAL_EN
    assign fast = is_div(bus.op_i) && (dz_in || ovf_in);
`else
    assign fast = 1'b0;
`endif

    always_comb begin
        a_ext = {{XLEN{is_signed(bus.op_i) & bus.a_i[XLEN-1]}}, bus.a_i};
        b_ext = {{XLEN{mul_b_signed(bus.op_i) & bus.b_i[XLEN-1]}}, bus.b_i};
        prod_in = a_ext * b_ext;
        a_abs = (is_signed(bus.op_i) && bus.a_i[XLEN-1]) ? -bus.a_i : bus.a_i;
        b_abs = (is_signed(bus.op_i) && bus.b_i[XLEN-1]) ? -bus.b_i : bus.b_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    if (is_div(bus.op_i)) begin
                        state_nx = fast ? S_DONE : S_DIV;
                    end else begin
                        state_nx = (MUL_STAGES == 1) ? S_DONE : S_MUL;
                    end
                end
            end
            S_MUL:  if (mcnt == MUL_LAST) state_nx = S_DONE;
            S_DIV:  if (div_done) state_nx = S_DONE;
            S_DONE: if (bus.ready_i) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (flush_i) state_nx = S_IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            tag_q <= '0;
            dz_q  <= 1'b0;
            ovf_q <= 1'b0;
            mcnt  <= '0;
        end else if (flush_i) begin
            mcnt <= '0;
        end else if (accept) begin
            op_q  <= bus.op_i;
            a_q   <= bus.a_i;
            b_q   <= bus.b_i;
            tag_q <= bus.tag_i;
            dz_q  <= is_div(bus.op_i) && dz_in;
            ovf_q <= is_div(bus.op_i) && ovf_in;
            mcnt  <= '0;
        end else if (state == S_MUL) begin
            mcnt <= mcnt + 1'b1;
        end
    end

    // Product enters stage 0 at accept and advances only while in S_MUL.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < MUL_STAGES; k++) prod_q[k] <= '0;
        end else begin
            if (accept) prod_q[0] <= prod_in;
            if (state == S_MUL) begin
                for (int k = 1; k < MUL_STAGES; k++) prod_q[k] <= prod_q[k-1];
            end
        end
    end

    assign prod_last = prod_q[MUL_STAGES-1];

    div_core #(.XLEN(XLEN)) u_div (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (accept && is_div(bus.op_i) && !fast),
        .abort_i    (flush_i),
        .dividend_i (a_abs),
        .divisor_i  (b_abs),
        .done_o     (div_done),
        .q_o        (q_mag),
        .r_o        (r_mag)
    );

    always_comb begin
        mul_res = (op_q == OP_MUL) ? prod_last[XLEN-1:0]
                                   : prod_last[2*XLEN-1:XLEN];
        q_fix = (is_signed(op_q) && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -q_mag : q_mag;
        r_fix = (is_signed(op_q) && a_q[XLEN-1]) ? -r_mag : r_mag;
        if (dz_q) begin
            q_fix = '1;
            r_fix = a_q;
        end else if (ovf_q) begin
            q_fix = a_q;
            r_fix = '0;
        end
        div_res = op_q[1] ? r_fix : q_fix;
    end

    assign bus.ready_o  = (state == S_IDLE);
    assign bus.valid_o  = (state == S_DONE);
    assign bus.result_o = (state == S_DONE) ? (is_div(op_q) ? div_res : mul_res) : '0;
    assign bus.tag_o    = (state == S_DONE) ? tag_q : '0;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table vectors, random model ops, backpressure and flush.
// Expected results queued at issue and compared when valid_o rises.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int MS = 2;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          lat;
    } exp_t;

    logic clk;
    logic rst;
    logic flush;
    int   checks;
    int   errors;
    exp_t sb[$];
    vec_t vecs[20];

    muldiv_if #(.XLEN(32), .TAG_W(5)) bus ();

    muldiv_unit #(.XLEN(32), .MUL_STAGES(MS), .TAG_W(5)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) return MS;
`ifdef MULDIV_FAST_SPECIAL_EN
        if (b == 32'h0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`endif
        return 33;
    endfunction

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'(a);
        longint ub = longint'(b);
        logic [63:0] p;
        logic ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            OP_MUL:    begin p = sa * sb; return p[31:0]; end
            OP_MULH:   begin p = sa * sb; return p[63:32]; end
            OP_MULHSU: begin p = sa * ub; return p[63:32]; end
            OP_MULHU:  begin p = ua * ub; return p[63:32]; end
            OP_DIV:    begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = sa / sb; return p[31:0];
            end
            OP_DIVU:   begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            OP_REM:    begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default:   begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] tag, input logic [31:0] res, input bit push);
        int w = 0;
        while (!bus.ready_o && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("ready_before_issue", {31'b0, bus.ready_o}, 32'd1);
        bus.valid_i = 1'b1;
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        bus.tag_i   = tag;
        if (push) sb.push_back('{res, tag, exp_lat(op, a, b)});
        @(posedge clk);
        @(negedge clk);
        bus.valid_i = 1'b0;
    endtask

    task automatic wait_result(input string name);
        int n = 1;
        exp_t e;
        while (!bus.valid_o && n < 100) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk($sformatf("%s.valid", name), {31'b0, bus.valid_o}, 32'd1);
        if (sb.size() == 0) begin
            chk($sformatf("%s.sb_empty", name), 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk($sformatf("%s.res", name), bus.result_o, e.res);
            chk($sformatf("%s.tag", name), {27'b0, bus.tag_o}, {27'b0, e.tag});
            chk($sformatf("%s.lat", name), n, e.lat);
        end
    endtask

    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag, input logic [31:0] res);
        start_op(op, a, b, tag, res, 1'b1);
        wait_result(name);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] bp_exp;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        bit          seen;

        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        flush       = 1'b0;
        bus.valid_i = 1'b0;
        bus.op_i    = '0;
        bus.a_i     = '0;
        bus.b_i     = '0;
        bus.tag_i   = '0;
        bus.ready_i = 1'b1;

        vecs[0]  = '{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[1]  = '{OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[2]  = '{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[3]  = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[4]  = '{OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[5]  = '{OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
        vecs[6]  = '{OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
        vecs[7]  = '{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[8]  = '{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[9]  = '{OP_DIVU,   32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[10] = '{OP_REMU,   32'h0000_0005, 32'h0000_0000, 32'h0000_0005};
        vecs[11] = '{OP_DIV,    32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[12] = '{OP_REM,    32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB};
        vecs[13] = '{OP_DIVU,   32'h0000_0064, 32'h0000_0007, 32'h0000_000E};
        vecs[14] = '{OP_REMU,   32'h0000_0064, 32'h0000_0007, 32'h0000_0002};
        vecs[15] = '{OP_DIV,    32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD};
        vecs[16] = '{OP_REM,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[17] = '{OP_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[18] = '{OP_REMU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[19] = '{OP_MUL,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst.ready_o",  {31'b0, bus.ready_o}, 32'd1);
        chk("rst.valid_o",  {31'b0, bus.valid_o}, 32'd0);
        chk("rst.result_o", bus.result_o, 32'd0);
        chk("rst.tag_o",    {27'b0, bus.tag_o}, 32'd0);

        for (int i = 0; i < 20; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  5'(i), vecs[i].res);
        end

        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            do_op($sformatf("rnd%0d", i), rop, ra, rb, 5'($urandom), model(rop, ra, rb));
        end

        // Consumer stalls 10 cycles with the result pending.
        bp_exp = model(OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0);
        bus.ready_i = 1'b0;
        start_op(OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd21, bp_exp, 1'b1);
        wait_result("bp");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp.hold_res",   bus.result_o, bp_exp);
            chk("bp.hold_tag",   {27'b0, bus.tag_o}, 32'd21);
            chk("bp.hold_ready", {31'b0, bus.ready_o}, 32'd0);
            chk("bp.hold_valid", {31'b0, bus.valid_o}, 32'd1);
        end
        bus.ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp.after_valid", {31'b0, bus.valid_o}, 32'd0);
        chk("bp.after_ready", {31'b0, bus.ready_o}, 32'd1);

        // Flush a divide at iteration 10.
        start_op(OP_DIV, 32'h0001_0000, 32'h0000_0003, 5'd9, 32'h0, 1'b0);
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
        end
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        chk("flush.ready", {31'b0, bus.ready_o}, 32'd1);
        chk("flush.valid", {31'b0, bus.valid_o}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            seen |= bus.valid_o;
        end
        chk("flush.no_valid", {31'b0, seen}, 32'd0);
        do_op("post_flush", OP_MUL, 32'h0000_1234, 32'h0000_0100, 5'd3, 32'h0012_3400);

        chk("sb.drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
